pong_tick_scheduler: RTL and testbench

PONG_TICK_SCHEDULER -- requirements
Module: pong_tick_scheduler

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_tick_counter.sv | 41 ++++
 rtl/pong_tick_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pong_tick_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong tick scheduler: FSM state encodings,
// default divider constants and the common counter width.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_WIN   = 3'd4
   } state_t;

   // Width of every cycle counter and of the ball period register.
   localparam int CNT_W = 24;

   // Default dividers for a 100 MHz system clock.
   localparam int PADDLE_DIV_DEF  = 500000;
   localparam int BALL_INIT_DEF   = 500000;
   localparam int BALL_STEP_DEF   = 10;
   localparam int BALL_MIN_DEF    = 100000;
   localparam int SERVE_TICKS_DEF = 30;

endpackage

// File: rtl/pong_tick_counter.sv
// Free-running period counter: counts 0..period-1 while enabled, wraps to 0
// and flags the terminal cycle. Clear has priority over enable.
module pong_tick_counter
   import pong_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_end;

   // Terminal-count detection and next count value. The >= keeps the counter
   // from running away if the period is ever lowered below the current count.
   always_comb begin
      at_end = (cnt_q >= (period_i - CNT_W'(1)));
      cnt_d  = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = at_end ? '0 : (cnt_q + CNT_W'(1));
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = enable_i && !clear_i && at_end;

endmodule

// File: rtl/pong_tick_scheduler.sv
// Game-phase FSM for pong plus the paddle and ball move-enable generators.
// Paddle ticks run at a fixed rate during SERVE and PLAY; ball ticks run
// only in PLAY and speed up after every ball tick down to a floor.
// Tick outputs are registered and gated by the next state, so a tick never
// appears in a cycle where the FSM has already left the running states.
module pong_tick_scheduler
   import pong_pkg::*;
#(
   parameter int PADDLE_DIV  = PADDLE_DIV_DEF,
   parameter int BALL_INIT   = BALL_INIT_DEF,
   parameter int BALL_STEP   = BALL_STEP_DEF,
   parameter int BALL_MIN    = BALL_MIN_DEF,
   parameter int SERVE_TICKS = SERVE_TICKS_DEF
)(
   input  logic        CLK_100MHz,
   input  logic        Reset,
   input  logic        start,
   input  logic        score,
   input  logic        win,
   output logic        tick_p,
   output logic        tick_b,
   output logic [2:0]  state,
   output logic [23:0] ball_period
);

   localparam logic [CNT_W-1:0] PADDLE_PERIOD = CNT_W'(PADDLE_DIV);
   localparam logic [CNT_W-1:0] BALL_INIT_P   = CNT_W'(BALL_INIT);
   localparam logic [CNT_W-1:0] BALL_STEP_P   = CNT_W'(BALL_STEP);
   localparam logic [CNT_W-1:0] BALL_MIN_P    = CNT_W'(BALL_MIN);
   localparam int               SRV_W         = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
   localparam logic [SRV_W-1:0] SERVE_LAST    = SRV_W'(SERVE_TICKS - 1);

   // Speed-up step with a floor; evaluated one bit wider so that the
   // subtraction can never wrap below zero.
   function automatic logic [CNT_W-1:0] step_down_sat(input logic [CNT_W-1:0] p);
      logic [CNT_W:0] floor_plus_step;
      floor_plus_step = {1'b0, BALL_MIN_P} + {1'b0, BALL_STEP_P};
      if ({1'b0, p} >= floor_plus_step) begin
         return p - BALL_STEP_P;
      end
      return BALL_MIN_P;
   endfunction

   state_t           state_q;
   state_t           state_d;
   logic [SRV_W-1:0] srv_q;
   logic [SRV_W-1:0] srv_d;
   logic             tick_p_q;
   logic             tick_p_d;
   logic             tick_b_q;
   logic             tick_b_d;
   logic [CNT_W-1:0] per_q;
   logic [CNT_W-1:0] per_d;

   logic             run_p;
   logic             run_b;
   logic             clr_p;
   logic             clr_b;
   logic             wrap_p;
   logic             wrap_b;

   // Next-state logic: start low wins over everything, win beats score.
   always_comb begin
      state_d = state_q;
      if (!start) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SERVE;
            end
            ST_SERVE: begin
               if (win) begin
                  state_d = ST_WIN;
               end else if (tick_p_q && (srv_q == SERVE_LAST)) begin
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (win) begin
                  state_d = ST_WIN;
               end else if (score) begin
                  state_d = ST_POINT;
               end
            end
            ST_POINT: begin
               state_d = win ? ST_WIN : ST_SERVE;
            end
            ST_WIN: begin
               state_d = ST_WIN;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Counter controls. The paddle phase survives SERVE->PLAY but restarts
   // from IDLE and after a point; the ball counter only lives inside PLAY,
   // so leaving PLAY (score, win or start drop) clears it.
   always_comb begin
      run_p = (state_q == ST_SERVE) || (state_q == ST_PLAY);
      run_b = (state_q == ST_PLAY);
      clr_p = (state_d == ST_IDLE) || (state_q == ST_IDLE) || (state_q == ST_POINT);
      clr_b = (state_d != ST_PLAY);
   end

   pong_tick_counter u_paddle_cnt (
      .clk_i    (CLK_100MHz),
      .rst_i    (Reset),
      .enable_i (run_p),
      .clear_i  (clr_p),
      .period_i (PADDLE_PERIOD),
      .tick_o   (wrap_p)
   );

   pong_tick_counter u_ball_cnt (
      .clk_i    (CLK_100MHz),
      .rst_i    (Reset),
      .enable_i (run_b),
      .clear_i  (clr_b),
      .period_i (per_q),
      .tick_o   (wrap_b)
   );

   // Tick gating, serve-tick counting and ball-period update.
   always_comb begin
      tick_p_d = wrap_p && ((state_d == ST_SERVE) || (state_d == ST_PLAY));
      // A score or win in the same cycle moves state_d off PLAY, which
      // drops the ball tick and therefore also its period decrement.
      tick_b_d = wrap_b && (state_d == ST_PLAY);

      srv_d = srv_q;
      if (state_q != ST_SERVE) begin
         srv_d = '0;
      end else if (tick_p_q) begin
         srv_d = srv_q + SRV_W'(1);
      end

      per_d = per_q;
      if ((state_d == ST_IDLE) || (state_q == ST_IDLE) || (state_q == ST_POINT)) begin
         per_d = BALL_INIT_P;
      end else if (tick_b_d) begin
         per_d = step_down_sat(per_q);
      end
   end

   // State, tick and period registers.
   always_ff @(posedge CLK_100MHz or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         srv_q    <= '0;
         tick_p_q <= 1'b0;
         tick_b_q <= 1'b0;
         per_q    <= BALL_INIT_P;
      end else begin
         state_q  <= state_d;
         srv_q    <= srv_d;
         tick_p_q <= tick_p_d;
         tick_b_q <= tick_b_d;
         per_q    <= per_d;
      end
   end

   assign tick_p      = tick_p_q;
   assign tick_b      = tick_b_q;
   assign state       = state_q;
   assign ball_period = per_q;

endmodule

// File: tb/tb_pong_tick_scheduler.sv
// Bench for pong_tick_scheduler: directed game scenarios followed by a
// randomized run, all checked against a cycle-level behavioural model.
module tb_pong_tick_scheduler;

   localparam int PD = 8;
   localparam int BI = 10;
   localparam int BS = 2;
   localparam int BM = 4;
   localparam int ST = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        score;
   logic        win;
   logic        tick_p;
   logic        tick_b;
   logic [2:0]  state;
   logic [23:0] ball_period;

   pong_tick_scheduler #(
      .PADDLE_DIV  (PD),
      .BALL_INIT   (BI),
      .BALL_STEP   (BS),
      .BALL_MIN    (BM),
      .SERVE_TICKS (ST)
   ) dut (
      .CLK_100MHz  (clk),
      .Reset       (rst),
      .start       (start),
      .score       (score),
      .win         (win),
      .tick_p      (tick_p),
      .tick_b      (tick_b),
      .state       (state),
      .ball_period (ball_period)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0, prev, ep, n, v;
   int tq[$];

   // Reference model: game phase, paddle phase (elapsed cycles, taken modulo
   // the divider), ball cycles since the last ball tick, current ball period,
   // paddle ticks seen in SERVE, and the registered tick outputs.
   int m_state, m_pel, m_bel, m_per, m_served;
   bit m_tp, m_tb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_pel    = 0;
      m_bel    = 0;
      m_per    = BI;
      m_served = 0;
      m_tp     = 1'b0;
      m_tb     = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit sc, input bit w);
      int ns;
      bit runp, runb, pw, bw;
      runp = (m_state == 1) || (m_state == 2);
      runb = (m_state == 2);
      pw   = runp && ((m_pel % PD) == PD - 1);
      bw   = runb && (m_bel == m_per - 1);
      if (!s) ns = 0;
      else begin
         case (m_state)
            0: ns = 1;
            1: ns = w ? 4 : ((m_tp && (m_served + 1 == ST)) ? 2 : 1);
            2: ns = w ? 4 : (sc ? 3 : 2);
            3: ns = w ? 4 : 1;
            4: ns = 4;
            default: ns = 0;
         endcase
      end
      m_served = (m_state == 1) ? m_served + int'(m_tp) : 0;
      if (ns == 0 || m_state == 3) m_pel = 0;
      else if (runp) m_pel++;
      if (ns != 2 || bw) m_bel = 0;
      else if (runb) m_bel++;
      m_tp = pw && (ns == 1 || ns == 2);
      m_tb = bw && (ns == 2);
      if (ns == 0 || m_state == 0 || m_state == 3) m_per = BI;
      else if (m_tb) m_per = (m_per - BS >= BM) ? m_per - BS : BM;
      m_state = ns;
   endtask

   task automatic check_model();
      chk("model_state",       32'(state),       32'(m_state));
      chk("model_tick_p",      32'(tick_p),      32'(m_tp));
      chk("model_tick_b",      32'(tick_b),      32'(m_tb));
      chk("model_ball_period", 32'(ball_period), 32'(m_per));
   endtask

   task automatic cycle(input bit s, input bit sc, input bit w);
      start = s;
      score = sc;
      win   = w;
      @(posedge clk);
      model_step(s, sc, w);
      cyc++;
      #1;
      check_model();
   endtask

   task automatic wait_state(input int target, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state == 3'(target)) begin
            found = 1'b1;
            break;
         end
         cycle(1'b1, 1'b0, 1'b0);
      end
      if (state == 3'(target)) found = 1'b1;
      chk("wait_state", 32'(found), 32'd1);
   endtask

   task automatic wait_tick_b(input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (tick_b === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_tick_b", 32'(found), 32'd1);
   endtask

   task automatic wait_tick_p(input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (tick_p === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_tick_p", 32'(found), 32'd1);
   endtask

   // Reset pulse placed between clock edges; outputs must clear at once.
   task automatic async_reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_state",       32'(state),       32'd0);
      chk("async_rst_tick_p",      32'(tick_p),      32'd0);
      chk("async_rst_tick_b",      32'(tick_b),      32'd0);
      chk("async_rst_ball_period", 32'(ball_period), 32'(BI));
      model_reset();
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: summary not reached within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      score = 1'b0;
      win   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("reset_state",       32'(state),       32'd0);
      chk("reset_tick_p",      32'(tick_p),      32'd0);
      chk("reset_tick_b",      32'(tick_b),      32'd0);
      chk("reset_ball_period", 32'(ball_period), 32'(BI));
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // Serve: paddle ticks every PD cycles, PLAY after the ST-th tick.
      cycle(1'b1, 1'b0, 1'b0);
      chk("serve_entry", 32'(state), 32'd1);
      t0 = cyc;
      tq.delete();
      for (int i = 0; i < 100 && state != 3'd2; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (tick_p === 1'b1) tq.push_back(cyc - t0);
      end
      chk("play_entry_cycle", 32'(cyc - t0), 32'(ST * PD + 1));
      chk("serve_tick_count", 32'(tq.size()), 32'(ST));
      for (int k = 0; k < ST; k++) begin
         v = (k < tq.size()) ? tq[k] : -1;
         chk("serve_tick_cycle", 32'(v), 32'((k + 1) * PD));
      end

      // Play: ball tick gaps shrink by BS down to BM.
      prev = cyc;
      ep   = BI;
      for (int k = 0; k < 5; k++) begin
         wait_tick_b(20);
         chk("tick_b_gap", 32'(cyc - prev), 32'(ep));
         prev = cyc;
         ep   = (ep - BS >= BM) ? ep - BS : BM;
      end
      chk("ball_period_floor", 32'(ball_period), 32'(BM));
      wait_tick_b(20);
      chk("floor_gap", 32'(cyc - prev), 32'(BM));
      chk("ball_period_hold", 32'(ball_period), 32'(BM));

      // Score: one POINT cycle, back to SERVE with the initial period.
      cycle(1'b1, 1'b1, 1'b0);
      chk("point_state", 32'(state), 32'd3);
      cycle(1'b1, 1'b0, 1'b0);
      chk("serve_after_point", 32'(state),       32'd1);
      chk("period_reload",     32'(ball_period), 32'(BI));
      t0 = cyc;
      n  = 0;
      for (int i = 0; i < 60 && state != 3'd2; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (tick_b === 1'b1) n++;
      end
      chk("no_tick_b_before_play", 32'(n), 32'd0);
      chk("replay_entry_cycle", 32'(cyc - t0), 32'(ST * PD + 1));

      // Win together with score: WIN holds with no ticks until start drops.
      cycle(1'b1, 1'b1, 1'b1);
      chk("win_beats_score", 32'(state), 32'd4);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n += int'(tick_p) + int'(tick_b);
      end
      chk("win_no_ticks", 32'(n), 32'd0);
      chk("win_hold", 32'(state), 32'd4);
      cycle(1'b0, 1'b0, 1'b0);
      chk("win_exit_idle", 32'(state), 32'd0);

      // Start dropped mid-PLAY: IDLE, counters and period restart.
      cycle(1'b1, 1'b0, 1'b0);
      wait_state(2, 60);
      wait_tick_b(20);
      chk("period_before_drop", 32'(ball_period), 32'(BI - BS));
      cycle(1'b0, 1'b0, 1'b0);
      chk("drop_to_idle",       32'(state),       32'd0);
      chk("drop_period_reload", 32'(ball_period), 32'(BI));
      cycle(1'b1, 1'b0, 1'b0);
      chk("serve_after_drop", 32'(state), 32'd1);
      t0 = cyc;
      wait_tick_p(20);
      chk("first_tick_p_after_restart", 32'(cyc - t0), 32'(PD));

      // Asynchronous reset right after a ball tick, then score in IDLE.
      wait_state(2, 60);
      wait_tick_b(20);
      chk("tick_b_before_reset", 32'(tick_b), 32'd1);
      async_reset_pulse();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         chk("idle_ignores_score", 32'(state), 32'd0);
      end
      cycle(1'b1, 1'b1, 1'b0);
      chk("serve_after_reset", 32'(state), 32'd1);

      // Randomized play against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 99) != 0),
               1'($urandom_range(0, 29) == 0),
               1'($urandom_range(0, 299) == 0));
         if ($urandom_range(0, 499) == 0) async_reset_pulse();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
